bt_cmd_arbiter: RTL and testbench

- Command scheduler between the Bluetooth UART byte receiver, the on-board mode buttons and the piano game core.
- Decodes received ASCII 'A'..'D' into one-hot mode codes and queues them in a small FIFO.
- Round-robin arbitrates the queue against button requests and offers one command at a time to the game core over a valid/ready handshake, with an acceptance timeout.
- Holds the last accepted code as the persistent mode select.

---
 rtl/bt_cmd_pkg.sv | 48 ++++
 rtl/bt_cmd_fifo.sv | 56 +++++
 rtl/bt_cmd_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bt_cmd_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_cmd_pkg.sv
// ============================================================================
//  Module      : bt_cmd_pkg
//  Description : Shared constants and helpers for the Bluetooth command arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bt_cmd_pkg;

  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_D = 8'h44;

  localparam logic [3:0] MODE_A    = 4'b0001;
  localparam logic [3:0] MODE_B    = 4'b0010;
  localparam logic [3:0] MODE_C    = 4'b0100;
  localparam logic [3:0] MODE_D    = 4'b1000;
  localparam logic [3:0] MODE_NONE = 4'b0000;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam logic SRC_BT  = 1'b0;
  localparam logic SRC_BTN = 1'b1;

  function automatic logic [3:0] decode_cmd(input logic [7:0] b);
    logic [3:0] code;
    case (b)
      CMD_A:   code = MODE_A;
      CMD_B:   code = MODE_B;
      CMD_C:   code = MODE_C;
      CMD_D:   code = MODE_D;
      default: code = MODE_NONE;
    endcase
    return code;
  endfunction

  // Isolates the lowest set bit (v & -v).
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    logic [3:0] r;
    r = v & (~v + 4'd1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bt_cmd_fifo.sv
// ============================================================================
//  Module      : bt_cmd_fifo
//  Description : Small synchronous FIFO; full/empty from extra pointer MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bt_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/bt_cmd_arbiter.sv
// ============================================================================
//  Module      : bt_cmd_arbiter
//  Description : Queues Bluetooth mode commands, round-robins them against
//                button requests and offers one at a time to the game core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bt_cmd_arbiter
  import bt_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  input  logic [3:0] btn_req,
  input  logic       cmd_ready,
  input  logic       err_clr,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       cmd_src,
  output logic [3:0] choose,
  output logic       ovf,
  output logic       tmo,
  output logic [7:0] bad_cnt
);

  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

  logic [3:0]       w_dec_code;
  logic             w_rx_bad;
  logic             r_dec_valid;
  logic [3:0]       r_dec_code;

  logic [3:0]       r_btn_q;
  logic [3:0]       r_btn_prev;
  logic [3:0]       r_btn_pend;
  logic [3:0]       w_btn_edge;

  logic [3:0]       w_fifo_data;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_bt_rdy;
  logic             w_btn_rdy;
  logic             w_sel_src;
  logic             w_load;
  logic             w_pop;
  logic             w_btn_take;
  logic             w_accept;
  logic             w_timeout;
  logic             w_ovf_set;

  logic             r_cmd_valid;
  logic [3:0]       r_cmd_code;
  logic             r_cmd_src;
  logic             r_last_src;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_choose;
  logic             r_ovf;
  logic             r_tmo;
  logic [7:0]       r_bad_cnt;

  always_comb begin
    w_dec_code = decode_cmd(rx_data);
    w_rx_bad   = rx_valid && (rx_frame_err || (w_dec_code == MODE_NONE));
  end

  assign w_btn_edge = r_btn_q & ~r_btn_prev;

  // Decode and button stages; a fresh edge always replaces the pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec_valid <= 1'b0;
      r_dec_code  <= MODE_NONE;
      r_btn_q     <= 4'b0000;
      r_btn_prev  <= 4'b0000;
      r_btn_pend  <= 4'b0000;
    end else begin
      r_dec_valid <= rx_valid && !w_rx_bad;
      r_dec_code  <= w_dec_code;
      r_btn_q     <= btn_req;
      r_btn_prev  <= r_btn_q;
      if (|w_btn_edge)     r_btn_pend <= lowest_one(w_btn_edge);
      else if (w_btn_take) r_btn_pend <= 4'b0000;
    end
  end

  bt_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_dec_valid),
    .i_data  (r_dec_code),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_bt_rdy    = !w_fifo_empty;
    w_btn_rdy   = |r_btn_pend;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_bt_rdy || w_btn_rdy) w_state_nxt = ST_OFFER;
      ST_OFFER: if (cmd_ready || (r_timer == TMR_LAST)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_src  = SRC_BT;
    w_load     = 1'b0;
    w_pop      = 1'b0;
    w_btn_take = 1'b0;
    w_accept   = 1'b0;
    w_timeout  = 1'b0;
    if (w_bt_rdy && w_btn_rdy) w_sel_src = ~r_last_src;
    else if (w_btn_rdy)        w_sel_src = SRC_BTN;
    if (r_state == ST_IDLE) begin
      w_load     = w_bt_rdy || w_btn_rdy;
      w_pop      = w_load && (w_sel_src == SRC_BT);
      w_btn_take = w_load && (w_sel_src == SRC_BTN);
    end else begin
      w_accept  = cmd_ready;
      w_timeout = !cmd_ready && (r_timer == TMR_LAST);
    end
    w_ovf_set = r_dec_valid && w_fifo_full && !w_pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= MODE_NONE;
      r_cmd_src   <= SRC_BT;
      r_last_src  <= SRC_BTN;
      r_timer     <= '0;
      r_choose    <= MODE_NONE;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_code  <= (w_sel_src == SRC_BT) ? w_fifo_data : r_btn_pend;
      r_cmd_src   <= w_sel_src;
      r_last_src  <= w_sel_src;
      r_timer     <= '0;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b0;
      r_choose    <= r_cmd_code;
    end else if (w_timeout) begin
      r_cmd_valid <= 1'b0;
    end else if (r_state == ST_OFFER) begin
      r_timer     <= r_timer + TMR_ONE;
    end
  end

  // Error bookkeeping; an event in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_tmo     <= 1'b0;
      r_bad_cnt <= 8'd0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_timeout)    r_tmo <= 1'b1;
      else if (err_clr) r_tmo <= 1'b0;
      if (w_rx_bad) begin
        if (err_clr)                   r_bad_cnt <= 8'd1;
        else if (r_bad_cnt != 8'd255)  r_bad_cnt <= r_bad_cnt + 8'd1;
      end else if (err_clr) begin
        r_bad_cnt <= 8'd0;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_src   = r_cmd_src;
  assign choose    = r_choose;
  assign ovf       = r_ovf;
  assign tmo       = r_tmo;
  assign bad_cnt   = r_bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bt_cmd_arbiter.sv
// ============================================================================
//  Module      : tb_bt_cmd_arbiter
//  Description : Scoreboard bench for bt_cmd_arbiter (short timeout build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bt_cmd_arbiter;
  import bt_cmd_pkg::*;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic [3:0] btn_req = 4'b0000;
  logic       cmd_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_src;
  logic [3:0] choose;
  logic       ovf;
  logic       tmo;
  logic [7:0] bad_cnt;

  always #5 clk = ~clk;

  bt_cmd_arbiter #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (27)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .btn_req      (btn_req),
    .cmd_ready    (cmd_ready),
    .err_clr      (err_clr),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_src      (cmd_src),
    .choose       (choose),
    .ovf          (ovf),
    .tmo          (tmo),
    .bad_cnt      (bad_cnt)
  );

  // len = 0 means the offer length is not checked (offer cut by reset).
  typedef struct packed {
    logic [3:0]  code;
    logic        src;
    logic [15:0] len;
  } offer_t;

  offer_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_offer(input logic [3:0] code, input logic src, input int len);
    exp_q.push_back('{code: code, src: src, len: 16'(len)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_data      = b;
    rx_frame_err = fe;
    rx_valid     = 1'b1;
    tick(1);
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cmd_valid) && k < bound) begin
      tick(1);
      k++;
    end
    check({name, "_drain"}, 32'(k < bound), 32'd1);
    tick(2);
  endtask

  // Monitor: each rising cmd_valid is a new offer, compared with the queue head.
  logic       mon_prev = 1'b0;
  int         mon_len  = 0;
  offer_t     mon_cur  = '0;
  logic [3:0] mon_code = 4'b0000;
  logic       mon_src  = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid) begin
      if (!mon_prev) begin
        check("offer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_cur = exp_q.pop_front();
          check("offer_code", 32'(cmd_code), 32'(mon_cur.code));
          check("offer_src", 32'(cmd_src), 32'(mon_cur.src));
        end else begin
          mon_cur = '0;
        end
        mon_len  = 1;
        mon_code = cmd_code;
        mon_src  = cmd_src;
      end else begin
        mon_len++;
        check("offer_stable", 32'({cmd_code, cmd_src}), 32'({mon_code, mon_src}));
      end
    end else if (mon_prev && mon_cur.len != 16'd0) begin
      check("offer_len", 32'(mon_len), 32'(mon_cur.len));
    end
    mon_prev = cmd_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    #1;
    check("reset_outputs", 32'({cmd_valid, cmd_code, cmd_src, choose, ovf, tmo, bad_cnt}), 32'd0);
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single Bluetooth byte, ready held high: latency and choose update.
    cmd_ready = 1'b1;
    expect_offer(MODE_B, SRC_BT, 1);
    rx_data  = CMD_B;
    rx_valid = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2) rx_valid = 1'b0;
      if (cmd_valid) break;
    end
    check("t1_latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("t1_pulse", 32'(cmd_valid), 32'd0);
    check("t1_choose", 32'(choose), 32'(MODE_B));
    tick(1);

    // Two bytes plus a button edge: round-robin order BT, BTN, BT.
    expect_offer(MODE_A, SRC_BT, 1);
    expect_offer(MODE_C, SRC_BTN, 1);
    expect_offer(MODE_D, SRC_BT, 1);
    send_byte(CMD_A, 1'b0);
    send_byte(CMD_D, 1'b0);
    btn_req = 4'b0100;
    wait_drain("t2", 50);
    check("t2_choose", 32'(choose), 32'(MODE_D));
    btn_req = 4'b0000;
    tick(3);

    // Rejected bytes: bad count, saturation, clear, clear-vs-event priority.
    send_byte(8'h45, 1'b0);
    send_byte(CMD_A, 1'b1);
    tick(1);
    check("t4_bad_cnt_2", 32'(bad_cnt), 32'd2);
    for (int i = 0; i < 300; i++) send_byte(8'h30 + 8'(i % 10), 1'b0);
    check("t4_bad_cnt_sat", 32'(bad_cnt), 32'd255);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_bad_cnt_clr", 32'(bad_cnt), 32'd0);
    err_clr = 1'b1;
    send_byte(8'h00, 1'b0);
    err_clr = 1'b0;
    check("t4_bad_cnt_clr_evt", 32'(bad_cnt), 32'd1);
    tick(2);

    // Simultaneous button edges, then a re-edge on bit 3 during the offer.
    cmd_ready = 1'b0;
    expect_offer(MODE_B, SRC_BTN, TMO);
    expect_offer(MODE_D, SRC_BTN, TMO);
    btn_req = 4'b1010;
    tick(3);
    btn_req = 4'b0010;
    tick(1);
    btn_req = 4'b1010;
    tick(1);
    wait_drain("t5", 100);
    check("t5_tmo", 32'(tmo), 32'd1);
    check("t5_choose_hold", 32'(choose), 32'(MODE_D));
    btn_req = 4'b0000;
    tick(3);

    // Fresh reset, then overflow and timeouts with ready held low.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    expect_offer(MODE_A, SRC_BTN, TMO);
    expect_offer(MODE_A, SRC_BT, TMO);
    expect_offer(MODE_B, SRC_BT, TMO);
    expect_offer(MODE_C, SRC_BT, TMO);
    expect_offer(MODE_D, SRC_BT, TMO);
    btn_req = 4'b0001;
    tick(4);
    btn_req = 4'b0000;
    send_byte(CMD_A, 1'b0);
    send_byte(CMD_B, 1'b0);
    send_byte(CMD_C, 1'b0);
    send_byte(CMD_D, 1'b0);
    send_byte(CMD_A, 1'b0);
    tick(2);
    check("t3_ovf", 32'(ovf), 32'd1);
    check("t3_tmo_early", 32'(tmo), 32'd0);
    wait_drain("t3", 300);
    check("t3_tmo", 32'(tmo), 32'd1);
    check("t3_choose", 32'(choose), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_flags_clr", 32'({ovf, tmo}), 32'd0);

    // Asynchronous reset in the middle of an offer with three queued entries.
    expect_offer(MODE_A, SRC_BT, 0);
    send_byte(CMD_A, 1'b0);
    send_byte(CMD_B, 1'b0);
    send_byte(CMD_C, 1'b0);
    send_byte(CMD_D, 1'b0);
    tick(3);
    check("t6_offer_active", 32'(cmd_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({cmd_valid, cmd_code, cmd_src, choose, ovf, tmo, bad_cnt}), 32'd0);
    tick(1);
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (cmd_valid) seen++;
    end
    check("t6_no_offer", 32'(seen), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
